// File: rtl/cv32e40p_tmr_fault_manager.sv
// ---------------------------------------------------------------------------
// cv32e40p_tmr_fault_manager
//
// Purpose: sequences one TMR-protected word. Votes the three replica words
// bitwise and tracks how often each replica disagrees with the majority
// using leaky saturating counters. A replica whose count reaches THRESH is
// handed to the resync machinery. A replica that needs MAX_RETRY resyncs is
// retired, and the word then runs in duplex (DEGRADED) mode until clear_i or
// reset.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   valid_i          replica words valid this cycle
//   res1_i..res3_i   replica words (index 0..2 internally)
//   clear_i          synchronous clear of all fault state
//   resync_ack_i     resync of resync_idx_o has completed
//   voted_o          registered voted word, held while valid_i=0
//   voted_valid_o    voted_o valid
//   resync_req_o     resync request, held until acknowledged
//   resync_idx_o     replica to resync (0..2)
//   disable_o        one-hot mask of the retired replica
//   multi_o          one-cycle pulse: two or more replicas disagreed
//   fatal_o          sticky: the two survivors disagreed in DEGRADED
//   irq_o            one-cycle pulse on DEGRADED entry or on fatal_o rising
// ---------------------------------------------------------------------------
module cv32e40p_tmr_fault_manager #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned THRESH    = 4,
  parameter int unsigned LEAK      = 16,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  input  logic             clear_i,
  input  logic             resync_ack_i,
  output logic [WIDTH-1:0] voted_o,
  output logic             voted_valid_o,
  output logic             resync_req_o,
  output logic [1:0]       resync_idx_o,
  output logic [2:0]       disable_o,
  output logic             multi_o,
  output logic             fatal_o,
  output logic             irq_o
);

  localparam int unsigned LeakW  = $clog2(LEAK);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]  CntMax    = '1;
  localparam logic [CNT_W-1:0]  ThreshC   = CNT_W'(THRESH);
  localparam logic [LeakW-1:0]  LeakLast  = LeakW'(LEAK - 1);
  localparam logic [RetryW-1:0] RetryLast = RetryW'(MAX_RETRY - 1);

  typedef enum logic [1:0] {
    StNormal,
    StResync,
    StDegraded
  } state_e;

  state_e                        state_q;
  logic [2:0][CNT_W-1:0]         cnt_q, cnt_d;
  logic [LeakW-1:0]              leak_q, leak_d;
  logic [2:0][RetryW-1:0]        retry_q;
  logic                          req_q;
  logic [1:0]                    resync_idx_q;
  logic [2:0]                    disable_q;
  logic                          multi_q, fatal_q, irq_q;
  logic [WIDTH-1:0]              voted_q;
  logic                          voted_valid_q;

  logic [2:0][WIDTH-1:0]         res;
  logic [WIDTH-1:0]              maj;
  logic [2:0]                    dis;
  logic                          twoPlus;
  logic [WIDTH-1:0]              survA, survB;
  logic                          overAny;
  logic [1:0]                    overIdx;
  logic                          ackTaken;

  assign res     = {res3_i, res2_i, res1_i};
  assign maj     = (res1_i & res2_i) | (res1_i & res3_i) | (res2_i & res3_i);
  assign twoPlus = (dis[0] & dis[1]) | (dis[0] & dis[2]) | (dis[1] & dis[2]);

  always_comb begin
    dis = '0;
    for (int k = 0; k < 3; k++) begin
      dis[k] = |(res[k] ^ maj);
    end
  end

  // The two survivors in duplex mode; survA is the lower index and feeds voted_o.
  always_comb begin
    survA = res1_i;
    survB = res2_i;
    if (disable_q[0]) begin
      survA = res2_i;
      survB = res3_i;
    end else if (disable_q[1]) begin
      survA = res1_i;
      survB = res3_i;
    end
  end

  // Lowest-index replica at or above threshold; the descending scan lets the
  // lowest index win.
  always_comb begin
    overAny = 1'b0;
    overIdx = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (cnt_q[k] >= ThreshC) begin
        overAny = 1'b1;
        overIdx = 2'(k);
      end
    end
  end

  assign ackTaken = (state_q == StResync) && resync_ack_i && !clear_i;

  // Counters only move on valid cycles outside DEGRADED. An acknowledged
  // resync zeroes its replica's counter, overriding the same cycle's update.
  always_comb begin
    cnt_d  = cnt_q;
    leak_d = leak_q;
    if (valid_i && (state_q != StDegraded)) begin
      if (|dis) begin
        leak_d = '0;
        for (int k = 0; k < 3; k++) begin
          if (dis[k] && !disable_q[k] && (cnt_q[k] != CntMax)) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
      end else if (leak_q == LeakLast) begin
        leak_d = '0;
        for (int k = 0; k < 3; k++) begin
          if ((cnt_q[k] != '0) && !disable_q[k]) begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
      end else begin
        leak_d = leak_q + 1'b1;
      end
    end
    if (ackTaken) begin
      cnt_d[resync_idx_q] = '0;
    end
    if (clear_i) begin
      cnt_d  = '0;
      leak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      leak_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      leak_q <= leak_d;
    end
  end

  // Voted word pipeline; clear_i deliberately does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_q       <= '0;
      voted_valid_q <= 1'b0;
    end else begin
      voted_valid_q <= valid_i;
      if (valid_i) begin
        voted_q <= (state_q == StDegraded) ? survA : maj;
      end
    end
  end

  // Fault sequencer. clear_i skips every state transition and event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StNormal;
      req_q        <= 1'b0;
      resync_idx_q <= 2'd0;
      retry_q      <= '0;
      disable_q    <= '0;
      fatal_q      <= 1'b0;
      irq_q        <= 1'b0;
      multi_q      <= 1'b0;
    end else begin
      irq_q   <= 1'b0;
      multi_q <= valid_i & twoPlus;
      if (clear_i) begin
        state_q   <= StNormal;
        req_q     <= 1'b0;
        retry_q   <= '0;
        disable_q <= '0;
        fatal_q   <= 1'b0;
      end else begin
        case (state_q)
          StNormal: begin
            if (overAny) begin
              state_q      <= StResync;
              req_q        <= 1'b1;
              resync_idx_q <= overIdx;
            end
          end
          StResync: begin
            if (resync_ack_i) begin
              req_q <= 1'b0;
              if (retry_q[resync_idx_q] == RetryLast) begin
                disable_q[resync_idx_q] <= 1'b1;
                irq_q                   <= 1'b1;
                state_q                 <= StDegraded;
              end else begin
                retry_q[resync_idx_q] <= retry_q[resync_idx_q] + 1'b1;
                state_q               <= StNormal;
              end
            end
          end
          StDegraded: begin
            if (valid_i && (survA != survB) && !fatal_q) begin
              fatal_q <= 1'b1;
              irq_q   <= 1'b1;
            end
          end
          default: state_q <= StNormal;
        endcase
      end
    end
  end

  assign voted_o       = voted_q;
  assign voted_valid_o = voted_valid_q;
  assign resync_req_o  = req_q;
  assign resync_idx_o  = resync_idx_q;
  assign disable_o     = disable_q;
  assign multi_o       = multi_q;
  assign fatal_o       = fatal_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_tmr_fault_manager
//
// Directed scenarios followed by a randomized phase, all checked against a
// behavioural model of the fault manager's rules.
// ---------------------------------------------------------------------------
module tb_cv32e40p_tmr_fault_manager;

  localparam int W         = 32;
  localparam int CNT_W     = 4;
  localparam int THRESH    = 4;
  localparam int LEAK      = 16;
  localparam int MAX_RETRY = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  localparam int M_NORMAL   = 0;
  localparam int M_RESYNC   = 1;
  localparam int M_DEGRADED = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          clear = 1'b0;
  logic          ack = 1'b0;
  logic [W-1:0]  r1 = '0, r2 = '0, r3 = '0;

  logic [W-1:0]  voted;
  logic          votedValid, req, multi, fatal, irq;
  logic [1:0]    idx;
  logic [2:0]    disMask;

  int compared = 0;
  int mismatched = 0;

  // Model state
  int            mCnt[3];
  int            mRetry[3];
  int            mLeak, mState, mIdx;
  bit            mReq, mFatal, mIrq, mMulti, mVValid;
  bit [2:0]      mDisable;
  logic [W-1:0]  mVoted;

  cv32e40p_tmr_fault_manager #(
    .WIDTH(W), .CNT_W(CNT_W), .THRESH(THRESH), .LEAK(LEAK), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid),
    .res1_i(r1), .res2_i(r2), .res3_i(r3),
    .clear_i(clear), .resync_ack_i(ack),
    .voted_o(voted), .voted_valid_o(votedValid),
    .resync_req_o(req), .resync_idx_o(idx),
    .disable_o(disMask), .multi_o(multi),
    .fatal_o(fatal), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Per-bit majority by counting ones.
  function automatic logic [W-1:0] modelVote(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      m[i] = (ones >= 2);
    end
    return m;
  endfunction

  task automatic modelReset();
    mCnt     = '{0, 0, 0};
    mRetry   = '{0, 0, 0};
    mLeak    = 0;
    mState   = M_NORMAL;
    mIdx     = 0;
    mReq     = 0;
    mFatal   = 0;
    mIrq     = 0;
    mMulti   = 0;
    mVValid  = 0;
    mDisable = '0;
    mVoted   = '0;
  endtask

  task automatic modelStep(input bit v, input logic [W-1:0] a, b, c,
                           input bit clr, input bit ak);
    logic [W-1:0] maj;
    logic [W-1:0] rs[3];
    bit           d[3];
    int           nd, oldState, s0, s1;
    bit           ackTaken;

    rs  = '{a, b, c};
    maj = modelVote(a, b, c);
    nd  = 0;
    for (int k = 0; k < 3; k++) begin
      d[k] = (rs[k] != maj);
      nd += int'(d[k]);
    end
    oldState = mState;
    s0 = -1;
    s1 = -1;
    for (int k = 0; k < 3; k++) begin
      if (!mDisable[k]) begin
        if (s0 < 0) s0 = k;
        else if (s1 < 0) s1 = k;
      end
    end

    mIrq    = 0;
    mMulti  = v && (nd >= 2);
    mVValid = v;
    if (v) mVoted = (oldState == M_DEGRADED) ? rs[s0] : maj;

    ackTaken = 0;
    if (!clr) begin
      if (oldState == M_NORMAL) begin
        for (int k = 2; k >= 0; k--) begin
          if (mCnt[k] >= THRESH) begin
            mIdx   = k;
            mReq   = 1;
            mState = M_RESYNC;
          end
        end
      end else if (oldState == M_RESYNC) begin
        if (ak) begin
          mReq     = 0;
          ackTaken = 1;
          if (mRetry[mIdx] + 1 == MAX_RETRY) begin
            mDisable[mIdx] = 1'b1;
            mIrq   = 1;
            mState = M_DEGRADED;
          end else begin
            mRetry[mIdx] = mRetry[mIdx] + 1;
            mState = M_NORMAL;
          end
        end
      end else begin
        if (v && (rs[s0] != rs[s1]) && !mFatal) begin
          mFatal = 1;
          mIrq   = 1;
        end
      end
    end

    if (v && (oldState != M_DEGRADED)) begin
      if (nd > 0) begin
        mLeak = 0;
        for (int k = 0; k < 3; k++) begin
          if (d[k] && mCnt[k] < CNT_MAX) mCnt[k] = mCnt[k] + 1;
        end
      end else if (mLeak == LEAK - 1) begin
        mLeak = 0;
        for (int k = 0; k < 3; k++) begin
          if (mCnt[k] > 0) mCnt[k] = mCnt[k] - 1;
        end
      end else begin
        mLeak = mLeak + 1;
      end
    end
    if (ackTaken) mCnt[mIdx] = 0;

    if (clr) begin
      mCnt     = '{0, 0, 0};
      mRetry   = '{0, 0, 0};
      mLeak    = 0;
      mDisable = '0;
      mFatal   = 0;
      mReq     = 0;
      mState   = M_NORMAL;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllOutputs(input string tag);
    checkOutput({tag, "/voted"}, voted, mVoted);
    checkOutput({tag, "/voted_valid"}, W'(votedValid), W'(mVValid));
    checkOutput({tag, "/req"}, W'(req), W'(mReq));
    if (mReq) checkOutput({tag, "/idx"}, W'(idx), W'(mIdx));
    checkOutput({tag, "/disable"}, W'(disMask), W'(mDisable));
    checkOutput({tag, "/multi"}, W'(multi), W'(mMulti));
    checkOutput({tag, "/fatal"}, W'(fatal), W'(mFatal));
    checkOutput({tag, "/irq"}, W'(irq), W'(mIrq));
  endtask

  // One clock of stimulus: drive pins, advance the model, check after the edge.
  task automatic applyStimulus(input string tag, input bit v, input logic [W-1:0] a, b, c,
                               input bit clr, input bit ak);
    valid = v;
    r1    = a;
    r2    = b;
    r3    = c;
    clear = clr;
    ack   = ak;
    modelStep(v, a, b, c, clr, ak);
    @(posedge clk);
    #1;
    checkAllOutputs(tag);
  endtask

  initial begin
    logic [W-1:0] base;
    logic [W-1:0] x[3];
    bit           v, clr, ak;

    base = 32'hA5A5A5A5;

    // Reset
    modelReset();
    #3;
    checkAllOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: identical replicas
    $display("[TB] scenario 1: clean voting");
    for (int i = 0; i < 10; i++) applyStimulus("s1", 1, base, base, base, 0, 0);
    checkOutput("s1_voted", voted, 32'hA5A5A5A5);
    checkOutput("s1_req", W'(req), '0);

    // 2: replica 1 wrong four times -> resync request, then ack
    $display("[TB] scenario 2: resync of replica 1");
    for (int i = 0; i < 4; i++) applyStimulus("s2_err", 1, base, base ^ 32'h1, base, 0, 0);
    checkOutput("s2_no_req_yet", W'(req), '0);
    applyStimulus("s2_wait", 1, base, base, base, 0, 0);
    checkOutput("s2_req", W'(req), W'(1));
    checkOutput("s2_idx", W'(idx), W'(1));
    applyStimulus("s2_hold", 0, base, base, base, 0, 0);
    applyStimulus("s2_ack", 1, base, base, base, 0, 1);
    checkOutput("s2_ack_req", W'(req), '0);
    applyStimulus("s2_after", 1, base, base, base, 0, 0);

    // 3: second resync of replica 1 retires it, then survivors disagree
    $display("[TB] scenario 3: retirement and fatal");
    for (int i = 0; i < 4; i++) applyStimulus("s3_err", 1, base, base ^ 32'h1, base, 0, 0);
    applyStimulus("s3_wait", 1, base, base, base, 0, 0);
    applyStimulus("s3_ack", 1, base, base, base, 0, 1);
    checkOutput("s3_disable", W'(disMask), W'(3'b010));
    checkOutput("s3_irq_degrade", W'(irq), W'(1));
    applyStimulus("s3_deg", 1, base, 32'h0, base, 0, 0);
    checkOutput("s3_irq_drop", W'(irq), '0);
    applyStimulus("s3_mis1", 1, base, base, base ^ 32'h10, 0, 0);
    checkOutput("s3_fatal", W'(fatal), W'(1));
    checkOutput("s3_irq_fatal", W'(irq), W'(1));
    applyStimulus("s3_mis2", 1, base, base, base ^ 32'h20, 0, 0);
    checkOutput("s3_irq_once", W'(irq), '0);
    applyStimulus("s3_clear", 1, base, base, base, 1, 0);
    checkOutput("s3_clear_fatal", W'(fatal), '0);

    // 4: leak decrement
    $display("[TB] scenario 4: leak");
    for (int i = 0; i < 3; i++) applyStimulus("s4_err", 1, base, base, base ^ 32'h100, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus("s4_clean", 1, base, base, base, 0, 0);
    applyStimulus("s4_err2", 1, base, base, base ^ 32'h100, 0, 0);
    applyStimulus("s4_c1", 1, base, base, base, 0, 0);
    applyStimulus("s4_c2", 1, base, base, base, 0, 0);
    checkOutput("s4_no_req", W'(req), '0);
    applyStimulus("s4_err3", 1, base, base, base ^ 32'h100, 0, 0);
    applyStimulus("s4_c3", 1, base, base, base, 0, 0);
    checkOutput("s4_req", W'(req), W'(1));
    checkOutput("s4_idx", W'(idx), W'(2));
    applyStimulus("s4_ack", 1, base, base, base, 0, 1);
    applyStimulus("s4_clear", 1, base, base, base, 1, 0);

    // 5: two replicas wrong on different bits
    $display("[TB] scenario 5: multi disagreement");
    applyStimulus("s5_multi", 1, base ^ 32'h8, base ^ 32'h80, base, 0, 0);
    checkOutput("s5_multi", W'(multi), W'(1));
    checkOutput("s5_voted", voted, base);
    applyStimulus("s5_after", 1, base, base, base, 0, 0);
    checkOutput("s5_multi_drop", W'(multi), '0);

    // 6: clear beats ack in RESYNC; async reset drops the request
    $display("[TB] scenario 6: clear and reset during resync");
    for (int i = 0; i < 4; i++) applyStimulus("s6_err", 1, base ^ 32'h4, base, base, 0, 0);
    applyStimulus("s6_wait", 1, base, base, base, 0, 0);
    checkOutput("s6_req", W'(req), W'(1));
    applyStimulus("s6_clear_ack", 1, base, base, base, 1, 1);
    checkOutput("s6_clear_req", W'(req), '0);
    applyStimulus("s6_stay", 1, base, base, base, 0, 0);
    checkOutput("s6_stay_normal", W'(req), '0);
    for (int i = 0; i < 4; i++) applyStimulus("s6_err2", 1, base ^ 32'h4, base, base, 0, 0);
    applyStimulus("s6_wait2", 1, base, base, base, 0, 0);
    checkOutput("s6_req2", W'(req), W'(1));
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("s6_async_req", W'(req), '0);
    checkAllOutputs("s6_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase
    $display("[TB] random phase");
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 99) < 80);
      base = $urandom;
      for (int k = 0; k < 3; k++) begin
        x[k] = base;
        if ($urandom_range(0, 9) == 0) x[k] = x[k] ^ (32'(1) << $urandom_range(0, 31));
      end
      ak  = mReq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 59) == 0);
      applyStimulus("rand", v, x[0], x[1], x[2], clr, ak);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
